// File: rtl/ram_access_ctrl_pkg.sv
// Shared constants for the sample-RAM access controller: geometry defaults,
// clear pattern and FSM state codes.
package ram_access_ctrl_pkg;

    localparam int         ADDR_W_DEF    = 15;
    localparam int         DATA_W_DEF    = 8;
    localparam int         RAM_DEPTH     = 1 << ADDR_W_DEF;
    localparam logic [7:0] CLR_VALUE_DEF = 8'h00;

    localparam logic [0:0] ST_ARB   = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

endpackage

// File: rtl/ram_rd_pipe.sv
// Read-return tag pipeline: a read command tag walks RD_LAT stages and the
// RAM q is captured when the tag reaches the last one.
module ram_rd_pipe
    import ram_access_ctrl_pkg::*;
#(
    parameter int RD_LAT = 2,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data
);

    logic [RD_LAT-1:0] vld_pipe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            vld_pipe[0] <= issue;
            for (int i = 1; i < RD_LAT; i++)
                vld_pipe[i] <= vld_pipe[i-1];
            rd_valid <= vld_pipe[RD_LAT-1];
            if (vld_pipe[RD_LAT-1])
                rd_data <= ram_rd_data;
        end
    end

endmodule

// File: rtl/ram_access_ctrl.sv
// Single owner of the sample RAM: arbitrates acquisition writes against host
// reads (with anti-starvation) and runs the zero-fill clear sweep.
module ram_access_ctrl
    import ram_access_ctrl_pkg::*;
#(
    parameter int                ADDR_W     = ADDR_W_DEF,
    parameter int                DATA_W     = DATA_W_DEF,
    parameter int                RD_LAT     = 2,
    parameter int                STARVE_MAX = 4,
    parameter logic [DATA_W-1:0] CLR_VALUE  = DATA_W'(CLR_VALUE_DEF)
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              acq_req,
    input  logic [ADDR_W-1:0] acq_addr,
    input  logic [DATA_W-1:0] acq_data,
    output logic              acq_gnt,
    input  logic              host_req,
    input  logic [ADDR_W-1:0] host_addr,
    output logic              host_gnt,
    output logic              host_rd_valid,
    output logic [DATA_W-1:0] host_rd_data,
    input  logic              clr_start,
    output logic              clr_done,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    output logic              ram_wr_en,
    input  logic [DATA_W-1:0] ram_rd_data
);

    localparam int SC_W = $clog2(STARVE_MAX + 1);

    logic [0:0]      state;
    logic [ADDR_W:0] clr_cnt;
    logic [SC_W-1:0] starve_cnt;
    logic            arb_open;
    logic            starved;

    // clr_start closes arbitration in its own cycle so the sweep starts clean
    assign arb_open = !sys_rst && (state == ST_ARB) && !clr_start;
    assign starved  = (starve_cnt == SC_W'(STARVE_MAX));
    assign host_gnt = arb_open && host_req && (!acq_req || starved);
    assign acq_gnt  = arb_open && acq_req && !host_gnt;
    assign busy     = (state == ST_CLEAR);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)
            starve_cnt <= '0;
        else if (!host_req || host_gnt)
            starve_cnt <= '0;
        else if (acq_gnt && !starved)
            starve_cnt <= starve_cnt + 1'b1;
    end

    // The sweep counter carries one extra bit; its MSB marks "all addresses issued".
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state       <= ST_ARB;
            clr_cnt     <= '0;
            ram_addr    <= '0;
            ram_wr_data <= '0;
            ram_wr_en   <= 1'b0;
            clr_done    <= 1'b0;
        end else begin
            ram_wr_en <= 1'b0;
            clr_done  <= 1'b0;
            case (state)
                ST_ARB: begin
                    if (clr_start) begin
                        state       <= ST_CLEAR;
                        ram_addr    <= '0;
                        ram_wr_data <= CLR_VALUE;
                        ram_wr_en   <= 1'b1;
                        clr_cnt     <= {{ADDR_W{1'b0}}, 1'b1};
                    end else if (acq_gnt) begin
                        ram_addr    <= acq_addr;
                        ram_wr_data <= acq_data;
                        ram_wr_en   <= 1'b1;
                    end else if (host_gnt) begin
                        ram_addr    <= host_addr;
                    end
                end
                default: begin
                    if (clr_cnt[ADDR_W]) begin
                        state    <= ST_ARB;
                        clr_done <= 1'b1;
                    end else begin
                        ram_addr    <= clr_cnt[ADDR_W-1:0];
                        ram_wr_data <= CLR_VALUE;
                        ram_wr_en   <= 1'b1;
                        clr_cnt     <= clr_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    ram_rd_pipe #(
        .RD_LAT (RD_LAT),
        .DATA_W (DATA_W)
    ) u_rd_pipe (
        .clk         (sys_clk),
        .rst         (sys_rst),
        .issue       (host_gnt),
        .ram_rd_data (ram_rd_data),
        .rd_valid    (host_rd_valid),
        .rd_data     (host_rd_data)
    );

endmodule
